mult_div_unit: RTL and testbench

Multicycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the ALU downstream of the register file. It takes rs/rt operands on a `start` pulse and runs a 32-iteration shift-add multiply or restoring divide. It then writes the 64-bit result into HI/LO and pulses `done`. `mfhi`/`mflo` datapath muxes read `hi`/`lo` directly; `mthi`/`mtlo` write them.

---
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle shift-add multiply / restoring divide with architectural HI/LO registers
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, op_i            launch (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled only in IDLE
//   a_i, b_i                 rs operand (multiplicand/dividend), rt operand (multiplier/divisor)
//   mthi_i, mtlo_i, wdata_i  direct HI/LO writes, honoured in IDLE when start_i is low
//   busy_o                   high whenever the unit is not IDLE
//   done_o, div_by_zero_o    one-cycle pulse after HI/LO update; divide-by-zero flag with done
//   hi_o, lo_o               HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic               done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   a_abs, b_abs, quot, rem;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic               signed_op;
    assign signed_op = ~op_i[0];
    assign a_abs     = (signed_op & a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (signed_op & b_i[WIDTH-1]) ? -b_i : b_i;
    // Multiply keeps the multiplier in acc[W-1:0] and grows the product from the top.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    // Divide trial-subtracts from the remainder as it will look after the left shift.
    assign div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign prod      = neg_res_q ? -acc_q : acc_q;
    // A zero divisor yields an all-ones quotient that must stay uncorrected; the remainder
    // is |a|, so re-applying the dividend sign restores the original a.
    assign quot      = (neg_res_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH);
                    div_d     = op_i[1];
                    neg_res_d = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d = signed_op & a_i[WIDTH-1];
                    dz_d      = op_i[1] & (b_i == '0);
                    acc_d     = {{WIDTH{1'b0}}, op_i[1] ? a_abs : b_abs};
                    opnd_d    = op_i[1] ? b_abs : a_abs;
                end else begin
                    hi_d = mthi_i ? wdata_i : hi_q;
                    lo_d = mtlo_i ? wdata_i : lo_q;
                end
            end
            RUN: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? FINISH : RUN;
                acc_d   = div_q ? (div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                                : (acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                            : {1'b0, acc_q[2*WIDTH-1:1]});
            end
            FINISH: begin
                state_d = IDLE;
                hi_d    = div_q ? rem  : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quot : prod[WIDTH-1:0];
                done_d  = 1'b1;
                dbz_d   = dz_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
    logic        clk_i, rst_ni, start_i, mthi_i, mtlo_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i, wdata_i;
    logic        busy_o, done_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        time         t0;
    } exp_t;
    exp_t sb[$];
    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    // Reference: plain integer arithmetic, C-style truncating division.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_, q, r;
        logic [63:0] p;
        e.t0 = 0;
        e.dz = 1'b0;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (op[1] && b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dz = 1'b1;
        end else if (op == 2'b00) begin
            p = sa * sb_;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op == 2'b10) begin
            q = sa / sb_;
            r = sa % sb_;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end else begin
            e.hi = a % b;
            e.lo = a / b;
        end
        return e;
    endfunction
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mtlo);
        exp_t e;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        mtlo_i  = with_mtlo;
        wdata_i = 32'hDEADBEEF;
        e = model(op, a, b);
        @(posedge clk_i);
        e.t0 = $time;
        sb.push_back(e);
        #1;
        start_i = 1'b0;
        mtlo_i  = 1'b0;
        op_i    = 2'($urandom);
        a_i     = $urandom;
        b_i     = $urandom;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clk_i);
    endtask
    initial begin : monitor
        int run = 0;
        int last_run = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (busy_o) run++;
            else begin
                last_run = run;
                run = 0;
            end
            if (prev_done) chk("done_width", {63'd0, done_o}, 64'd0);
            if (done_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done hi=%h lo=%h required=no_done", hi_o, lo_o);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
                    chk("lo", {32'd0, lo_o}, {32'd0, e.lo});
                    chk("div_by_zero", {63'd0, div_by_zero_o}, {63'd0, e.dz});
                    chk("latency", 64'($time - e.t0), 64'd335);
                    chk("busy_cycles", 64'(last_run), 64'd33);
                    chk("busy_low_at_done", {63'd0, busy_o}, 64'd0);
                end
            end
            prev_done = done_o;
        end
    end
    initial begin : driver
        logic [31:0] hold, r_a, r_b;
        logic [1:0]  r_op;
        rst_ni = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        op_i = 2'd0; a_i = '0; b_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero_o}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        rst_ni = 1'b1;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
        issue(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);        wait_idle();
        issue(2'b00, 32'h80000000, 32'h80000000, 1'b0); wait_idle();
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);        wait_idle();
        issue(2'b11, 32'd100, 32'd7, 1'b0);             wait_idle();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();
        issue(2'b11, 32'd100, 32'd0, 1'b0);             wait_idle();
        issue(2'b10, 32'hFFFFFF9C, 32'd0, 1'b0);        wait_idle();
        issue(2'b10, 32'd100, 32'hFFFFFFF9, 1'b0);      wait_idle();
        // busy-time start and mthi are both ignored
        issue(2'b01, 32'd1234, 32'd5678, 1'b0);
        repeat (5) @(negedge clk_i);
        hold = hi_o;
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd999; b_i = 32'd3;
        mthi_i = 1'b1; wdata_i = 32'hA5A5A5A5;
        @(negedge clk_i);
        start_i = 1'b0; mthi_i = 1'b0;
        chk("busy_mthi_ignored", {32'd0, hi_o}, {32'd0, hold});
        wait_idle();
        // IDLE writes
        mthi_i = 1'b1; wdata_i = 32'h12345678;
        hold = lo_o;
        @(posedge clk_i);
        #1 mthi_i = 1'b0;
        chk("mthi_hi", {32'd0, hi_o}, 64'h12345678);
        chk("mthi_lo_kept", {32'd0, lo_o}, {32'd0, hold});
        chk("mthi_no_done", {63'd0, done_o}, 64'd0);
        @(negedge clk_i);
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hCAFEF00D;
        @(posedge clk_i);
        #1 mthi_i = 1'b0; mtlo_i = 1'b0;
        chk("mthilo_hi", {32'd0, hi_o}, 64'hCAFEF00D);
        chk("mthilo_lo", {32'd0, lo_o}, 64'hCAFEF00D);
        // start wins over mtlo
        hold = lo_o;
        issue(2'b11, 32'd50, 32'd6, 1'b1);
        chk("start_mtlo_dropped", {32'd0, lo_o}, {32'd0, hold});
        wait_idle();
        // async reset aborts an in-flight MULT
        issue(2'b00, 32'd77, 32'd88, 1'b0);
        repeat (9) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_hi", {32'd0, hi_o}, 64'd0);
        chk("abort_lo", {32'd0, lo_o}, 64'd0);
        chk("abort_done", {63'd0, done_o}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        issue(2'b11, 32'd9, 32'd3, 1'b0); wait_idle();
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 15);
                2:       r_b = 32'hFFFFFFFF;
                default: r_b = $urandom;
            endcase
            issue(r_op, r_a, r_b, 1'b0);
            wait_idle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
